// File: rtl/led_pattern_sequencer_if.sv
// Control and pattern bundle for led_pattern_sequencer.
// The master drives run, clear and mode, and the slave returns tick and pattern.
interface led_pattern_sequencer_if #(
  parameter int unsigned CH = 2
);
  logic          enable;
  logic          clear;
  logic [1:0]    mode;
  logic          tick;
  logic [CH-1:0] pattern;

  modport master (output enable, clear, mode, input  tick, pattern);
  modport slave  (input  enable, clear, mode, output tick, pattern);
endinterface

// File: rtl/led_pattern_sequencer.sv
// Programmable prescaler with a one-cycle tick every DIVIDE clocks.
// Drives a CH-bit status pattern: binary, walking one, Gray or blink.
module led_pattern_sequencer #(
  parameter int unsigned DIVIDE    = 14318180,
  parameter int unsigned CNT_WIDTH = 24,
  parameter int unsigned CH        = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  led_pattern_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    MODE_BIN   = 2'b00,
    MODE_WALK  = 2'b01,
    MODE_GRAY  = 2'b10,
    MODE_BLINK = 2'b11
  } mode_t;

  localparam logic [CNT_WIDTH-1:0] LAST      = CNT_WIDTH'(DIVIDE - 1);
  localparam logic [CNT_WIDTH-1:0] HALF      = CNT_WIDTH'(DIVIDE / 2);
  localparam logic [CH-1:0]        RING_INIT = CH'(1);

  logic [CNT_WIDTH-1:0] presc, presc_n, presc_cur;
  logic [CH-1:0]        seq, seq_n;
  logic [CH-1:0]        ring, ring_n;
  logic                 tick_n;
  logic [CH-1:0]        pattern_n;
  mode_t                mode_e;

  assign mode_e = mode_t'(bus.mode);

  always_comb begin
    presc_n   = presc;
    seq_n     = seq;
    ring_n    = ring;
    tick_n    = 1'b0;
    presc_cur = presc;
    pattern_n = '0;
    // Blink samples the pre-edge prescaler, so a clear restarts it from zero too.
    if (bus.clear) begin
      presc_n   = '0;
      seq_n     = '0;
      ring_n    = RING_INIT;
      presc_cur = '0;
    end else if (bus.enable) begin
      if (presc == LAST) begin
        presc_n = '0;
        tick_n  = 1'b1;
        seq_n   = seq + CH'(1);
        ring_n  = {ring[CH-2:0], ring[CH-1]};
      end else begin
        presc_n = presc + CNT_WIDTH'(1);
      end
    end
    case (mode_e)
      MODE_BIN:   pattern_n = seq_n;
      MODE_WALK:  pattern_n = ring_n;
      MODE_GRAY:  pattern_n = seq_n ^ (seq_n >> 1);
      MODE_BLINK: pattern_n = {CH{presc_cur < HALF}};
      default:    pattern_n = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc       <= '0;
      seq         <= '0;
      ring        <= RING_INIT;
      bus.tick    <= 1'b0;
      bus.pattern <= '0;
    end else begin
      presc       <= presc_n;
      seq         <= seq_n;
      ring        <= ring_n;
      bus.tick    <= tick_n;
      bus.pattern <= pattern_n;
    end
  end

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Directed bench for led_pattern_sequencer with DIVIDE=4 and CH=3.
module tb_led_pattern_sequencer;

  localparam int unsigned DIV = 4;
  localparam int unsigned CW  = 8;
  localparam int unsigned CHN = 3;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  led_pattern_sequencer_if #(.CH(CHN)) bus ();

  led_pattern_sequencer #(
    .DIVIDE    (DIV),
    .CNT_WIDTH (CW),
    .CH        (CHN)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance n edges and settle 1 time unit after the last one.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called 1 unit after an edge: reset must act before the next edge.
  task automatic do_reset(input string tag);
    reset = 1'b1;
    #1;
    check({tag, "_tick"}, {31'd0, bus.tick}, 32'd0);
    check({tag, "_pat"},  {29'd0, bus.pattern}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    bus.enable = 1'b1;
    bus.clear  = 1'b0;
    bus.mode   = 2'b00;
    #1 reset = 1'b1;
    #3;
    check("rst_tick", {31'd0, bus.tick}, 32'd0);
    check("rst_pat",  {29'd0, bus.pattern}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Binary count: tick on every 4th edge, pattern counts ticks mod 8.
    for (int e = 1; e <= 36; e++) begin
      step(1);
      check("bin_tick", {31'd0, bus.tick}, (e % 4 == 0) ? 32'd1 : 32'd0);
      check("bin_pat",  {29'd0, bus.pattern}, 32'((e / 4) % 8));
    end

    // Walking one, then switch to Gray with seq=3.
    bus.mode = 2'b01;
    do_reset("rst2");
    step(1);  check("walk_e1",  {29'd0, bus.pattern}, 32'b001);
    step(3);  check("walk_e4",  {29'd0, bus.pattern}, 32'b010);
              check("walk_t4",  {31'd0, bus.tick}, 32'd1);
    step(4);  check("walk_e8",  {29'd0, bus.pattern}, 32'b100);
    step(4);  check("walk_e12", {29'd0, bus.pattern}, 32'b001);
    bus.mode = 2'b10;
    step(1);  check("gray_sw",  {29'd0, bus.pattern}, 32'b010);
              check("gray_swt", {31'd0, bus.tick}, 32'd0);
    step(2);  check("gray_hold", {29'd0, bus.pattern}, 32'b010);
    step(1);  check("gray_tick", {31'd0, bus.tick}, 32'd1);
              check("gray_pat",  {29'd0, bus.pattern}, 32'b110);

    // Blink: 111,111,000,000 per period, ticks unaffected.
    bus.mode = 2'b11;
    for (int k = 1; k <= 8; k++) begin
      step(1);
      check("blink_pat",  {29'd0, bus.pattern}, (((k - 1) % 4) < 2) ? 32'b111 : 32'b000);
      check("blink_tick", {31'd0, bus.tick}, (k % 4 == 0) ? 32'd1 : 32'd0);
    end

    // Freeze at presc=2 (seq=6), then resume.
    bus.mode = 2'b00;
    step(2);  check("frz_pre", {29'd0, bus.pattern}, 32'd6);
    bus.enable = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step(1);
      check("frz_tick", {31'd0, bus.tick}, 32'd0);
      check("frz_pat",  {29'd0, bus.pattern}, 32'd6);
    end
    bus.enable = 1'b1;
    step(1);  check("res_t1",  {31'd0, bus.tick}, 32'd0);
    step(1);  check("res_t2",  {31'd0, bus.tick}, 32'd1);
              check("res_pat", {29'd0, bus.pattern}, 32'd7);

    // Clear on a period-end edge with seq=5.
    do_reset("rst3");
    step(20); check("clr_seq5", {29'd0, bus.pattern}, 32'd5);
    step(3);
    bus.clear = 1'b1;
    step(1);  check("clr_tick", {31'd0, bus.tick}, 32'd0);
              check("clr_pat",  {29'd0, bus.pattern}, 32'd0);
    bus.clear = 1'b0;
    step(3);  check("clr_notick", {31'd0, bus.tick}, 32'd0);
              check("clr_hold",   {29'd0, bus.pattern}, 32'd0);
    step(1);  check("clr_tick4",  {31'd0, bus.tick}, 32'd1);
              check("clr_pat4",   {29'd0, bus.pattern}, 32'd1);

    // Asynchronous reset while tick is high, then normal restart.
    do_reset("rst_async");
    step(3);  check("post_notick", {31'd0, bus.tick}, 32'd0);
    step(1);  check("post_tick",   {31'd0, bus.tick}, 32'd1);
              check("post_pat",    {29'd0, bus.pattern}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
